// File: rtl/mux_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined bus mux.
package mux_pkg;

  localparam int GROUP_SIZE = 4;

  function automatic int clog2(input int n);
    int r = 0;
    int v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int group_count(input int n_ch);
    return (n_ch + GROUP_SIZE - 1) / GROUP_SIZE;
  endfunction

  // Number of 4:1 levels needed to reduce n_groups group outputs to one.
  function automatic int tree_levels(input int n_groups);
    int lv  = 1;
    int cap = GROUP_SIZE;
    while (cap < n_groups) begin
      cap = cap * GROUP_SIZE;
      lv++;
    end
    return lv;
  endfunction

  // Index of the first node of tree level l in a flat node array (level 0 = leaves).
  function automatic int tree_offset(input int levels, input int l);
    int off = 0;
    for (int i = 0; i < l; i++) off += GROUP_SIZE ** (levels - i);
    return off;
  endfunction

endpackage

// File: rtl/mux4_bus.sv
// Combinational 4:1 multiplexer over WIDTH-bit buses; d holds inputs 0..3 from LSB up.
module mux4_bus #(
  parameter int WIDTH = 8
) (
  input  logic [4*WIDTH-1:0] d,
  input  logic [1:0]         sel,
  output logic [WIDTH-1:0]   y
);

  always_comb begin
    // NOTE: default assignment first so every path drives y and no latch is inferred.
    y = '0;
    case (sel)
      2'd0: y = d[0*WIDTH +: WIDTH];
      2'd1: y = d[1*WIDTH +: WIDTH];
      2'd2: y = d[2*WIDTH +: WIDTH];
      2'd3: y = d[3*WIDTH +: WIDTH];
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mux_pipe_sel.sv
// Two-stage pipelined N_CH:1 bus mux with valid/ready backpressure, auto-scan and range flag.
module mux_pipe_sel
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_CH  = 16,
  parameter int SEL_W = clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_chan,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int G      = group_count(N_CH);
  localparam int LV     = tree_levels(G);
  localparam int LEAVES = GROUP_SIZE ** LV;
  localparam int TOTAL  = tree_offset(LV, LV) + 1;
  localparam int HI_W   = 2 * LV;

  logic             en;
  logic             accept;
  logic [SEL_W-1:0] scan_ptr;
  logic [SEL_W-1:0] idx;
  logic [1:0]       idx_lo;

  logic [WIDTH-1:0] chan    [GROUP_SIZE*G];
  logic [WIDTH-1:0] grp_mux [G];
  logic [WIDTH-1:0] grp_q   [G];
  logic [SEL_W-1:0] idx_q;
  logic             err_q;
  logic             v1;
  logic [HI_W-1:0]  idx_hi;
  logic [WIDTH-1:0] node    [TOTAL];

  // Global stall: both stages move together, so a full pipe never squeezes out bubbles.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  assign idx    = mode ? scan_ptr : in_sel;
  assign idx_lo = 2'(idx);

  for (genvar k = 0; k < GROUP_SIZE*G; k++) begin : g_chan
    if (k < N_CH) begin : g_real
      assign chan[k] = in_data[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign chan[k] = '0;
    end
  end

  for (genvar g = 0; g < G; g++) begin : g_grp
    mux4_bus #(.WIDTH(WIDTH)) u_grp (
      .d   ({chan[4*g+3], chan[4*g+2], chan[4*g+1], chan[4*g]}),
      .sel (idx_lo),
      .y   (grp_mux[g])
    );
  end

  // Entering scan mode always starts from channel 0 because mode=0 holds the pointer cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_ptr <= '0;
    end else if (!mode) begin
      scan_ptr <= '0;
    end else if (accept) begin
      // NOTE: non-blocking for all sequential state so every register samples pre-edge values.
      scan_ptr <= (scan_ptr == SEL_W'(N_CH - 1)) ? '0 : scan_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else if (en) begin
      v1    <= in_valid;
      idx_q <= idx;
      err_q <= {1'b0, idx} >= (SEL_W+1)'(N_CH);
    end
  end

  // NOTE: group data registers carry no reset; v1/out_valid qualify them and this keeps the wide datapath cheap.
  always_ff @(posedge clk) begin
    if (en) grp_q <= grp_mux;
  end

  // Stage-2 tree: leaves are the registered groups (zero-padded), each level consumes two index bits.
  assign idx_hi = HI_W'(idx_q >> 2);

  for (genvar j = 0; j < LEAVES; j++) begin : g_leaf
    if (j < G) begin : g_used
      assign node[j] = grp_q[j];
    end else begin : g_pad
      assign node[j] = '0;
    end
  end

  for (genvar l = 1; l <= LV; l++) begin : g_lvl
    localparam int NODES = GROUP_SIZE ** (LV - l);
    localparam int OFF   = tree_offset(LV, l);
    localparam int PREV  = tree_offset(LV, l - 1);
    for (genvar j = 0; j < NODES; j++) begin : g_node
      mux4_bus #(.WIDTH(WIDTH)) u_node (
        .d   ({node[PREV+4*j+3], node[PREV+4*j+2], node[PREV+4*j+1], node[PREV+4*j]}),
        .sel (idx_hi[2*(l-1) +: 2]),
        .y   (node[OFF+j])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_data  <= err_q ? '0 : node[TOTAL-1];
      out_chan  <= idx_q;
      out_err   <= err_q;
      out_valid <= v1;
    end
  end

endmodule

// File: tb/tb_mux_pipe_sel.sv
// Directed bench for mux_pipe_sel (16-channel and 10-channel instances) plus a scoreboarded random run.
module tb_mux_pipe_sel;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [127:0] in_data;
  logic [3:0]   in_sel;
  logic         mode, in_valid, in_ready, out_err, out_valid, out_ready;
  logic [7:0]   out_data;
  logic [3:0]   out_chan;

  logic [79:0]  d10_in_data;
  logic [3:0]   d10_in_sel;
  logic         d10_mode, d10_in_valid, d10_in_ready, d10_out_err, d10_out_valid, d10_out_ready;
  logic [7:0]   d10_out_data;
  logic [3:0]   d10_out_chan;

  mux_pipe_sel #(.WIDTH(8), .N_CH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_chan(out_chan),
    .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_pipe_sel #(.WIDTH(8), .N_CH(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .in_data(d10_in_data), .in_sel(d10_in_sel), .mode(d10_mode),
    .in_valid(d10_in_valid), .in_ready(d10_in_ready), .out_data(d10_out_data), .out_chan(d10_out_chan),
    .out_err(d10_out_err), .out_valid(d10_out_valid), .out_ready(d10_out_ready)
  );

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] c;
    logic       e;
  } item_t;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] sels10 [4] = '{4'd12, 4'd9, 4'd3, 4'd15};
    logic       errs10 [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] data10 [4] = '{8'h00, 8'hA9, 8'hA3, 8'h00};
    item_t      q [$];
    item_t      exp_item;
    logic [3:0] scan_m, idx;
    int         next_in, next_out, exp_chan;
    logic       exp_valid;

    rst_n = 1'b0;
    in_valid = 1'b0; in_sel = '0; mode = 1'b0; out_ready = 1'b1;
    d10_in_valid = 1'b0; d10_in_sel = '0; d10_mode = 1'b0; d10_out_ready = 1'b1;
    for (int k = 0; k < 16; k++) in_data[k*8 +: 8] = 8'(8'h10 + k);
    for (int k = 0; k < 10; k++) d10_in_data[k*8 +: 8] = 8'(8'hA0 + k);

    // Reset state
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_chan",  32'(out_chan),  32'd0);
    check("rst_err",   32'(out_err),   32'd0);
    check("rst_ready", 32'(in_ready),  32'd1);
    rst_n = 1'b1;

    // Direct mode, channels 0..15 back-to-back, results two cycles after accept
    for (int i = 0; i <= 18; i++) begin
      if (i >= 2 && i < 18) begin
        check("dir_valid", 32'(out_valid), 32'd1);
        check("dir_data",  32'(out_data),  32'(8'h10 + i - 2));
        check("dir_chan",  32'(out_chan),  32'(i - 2));
        check("dir_err",   32'(out_err),   32'd0);
      end else begin
        check("dir_idle", 32'(out_valid), 32'd0);
      end
      check("dir_ready", 32'(in_ready), 32'd1);
      in_valid = (i < 16);
      in_sel   = 4'(i);
      tick();
    end

    // Backpressure: out_ready low for 5 cycles while channel 2 is presented
    next_in = 0; next_out = 0;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 4 && c < 9);
      in_valid  = (next_in < 8);
      in_sel    = 4'(next_in);
      #1;
      if (c >= 4 && c < 9) begin
        check("bp_ready", 32'(in_ready),  32'd0);
        check("bp_hold_chan", 32'(out_chan), 32'd2);
        check("bp_hold_data", 32'(out_data), 32'h12);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
      end
      if (in_valid && in_ready) next_in++;
      if (out_valid && out_ready) begin
        check("bp_chan", 32'(out_chan), 32'(next_out));
        check("bp_data", 32'(out_data), 32'(8'h10 + next_out));
        next_out++;
      end
      tick();
    end
    check("bp_count", 32'(next_out), 32'd8);
    check("bp_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b1;

    // Scan: 18 accepts wrap 0..15,0,1; one direct accept of 5; scan restarts at 0
    for (int c = 0; c <= 22; c++) begin
      exp_valid = (c >= 2 && c <= 21);
      exp_chan  = (c <= 19) ? (c - 2) % 16 : (c == 20) ? 5 : 0;
      check("scan_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) begin
        check("scan_chan", 32'(out_chan), 32'(exp_chan));
        check("scan_data", 32'(out_data), 32'(8'h10 + exp_chan));
      end
      mode     = (c != 18);
      in_valid = (c < 20);
      in_sel   = (c == 18) ? 4'd5 : 4'hA;
      tick();
    end
    mode = 1'b0;
    in_valid = 1'b0;

    // 10-channel instance: out-of-range select and the partial last group
    for (int c = 0; c <= 6; c++) begin
      if (c >= 2 && c < 6) begin
        check("n10_valid", 32'(d10_out_valid), 32'd1);
        check("n10_err",   32'(d10_out_err),   32'(errs10[c-2]));
        check("n10_data",  32'(d10_out_data),  32'(data10[c-2]));
        check("n10_chan",  32'(d10_out_chan),  32'(sels10[c-2]));
      end else begin
        check("n10_idle", 32'(d10_out_valid), 32'd0);
      end
      d10_in_valid = (c < 4);
      d10_in_sel   = (c < 4) ? sels10[c] : 4'd0;
      tick();
    end
    d10_in_valid = 1'b0;

    // Asynchronous reset with two scan transfers in flight
    mode = 1'b1; in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    check("ar_pre_chan",  32'(out_chan),  32'd0);
    rst_n = 1'b0;
    #1;
    check("ar_valid_drop", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("ar_no_emit", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("ar_scan_valid", 32'(out_valid), 32'd1);
    check("ar_scan_chan",  32'(out_chan),  32'd0);
    check("ar_scan_data",  32'(out_data),  32'h10);
    mode = 1'b0;
    tick();

    // Random traffic against a scoreboard queue
    scan_m = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      in_sel  = 4'($urandom);
      in_data = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (out_valid && out_ready) begin
        exp_item = (q.size() > 0) ? q.pop_front() : '1;
        check("rnd_out", 32'({out_data, out_chan, out_err}), 32'(exp_item));
      end
      idx = mode ? scan_m : in_sel;
      if (in_valid && in_ready) begin
        q.push_back('{d: in_data[int'(idx)*8 +: 8], c: idx, e: 1'b0});
        if (mode) scan_m = (scan_m == 4'd15) ? 4'd0 : scan_m + 4'd1;
      end
      if (!mode) scan_m = '0;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) begin
        exp_item = (q.size() > 0) ? q.pop_front() : '1;
        check("rnd_drain", 32'({out_data, out_chan, out_err}), 32'(exp_item));
      end
      tick();
    end
    check("rnd_left", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
